// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to DONE with all-ones quotient.
module seq_div #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   partial;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      partial = {rem_q, dvd_q[WIDTH-1]};
      // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
      diff    = partial[WIDTH-1:0] - dvs_q;
      ge      = (partial >= {1'b0, dvs_q});

      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d = dividend;
               dvs_d = divisor;
               cnt_d = '0;
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  quo_d   = '0;
                  rem_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            if (ge) begin
               rem_d = diff;
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = partial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_CALC);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div at WIDTH=16 and WIDTH=8; expected results queued at start, popped at done.
module tb_seq_div;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start16 = 1'b0, start8 = 1'b0;
   logic [15:0] dvd16 = '0, dvs16 = '0;
   logic [7:0]  dvd8 = '0, dvs8 = '0;
   logic        busy16, done16, dbz16, busy8, done8, dbz8;
   logic [15:0] quo16, rem16;
   logic [7:0]  quo8, rem8;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   seq_div #(.WIDTH(16)) dut16 (
      .CLK(CLK), .RST(RST), .start(start16), .dividend(dvd16), .divisor(dvs16),
      .busy(busy16), .done(done16), .div_by_zero(dbz16),
      .quotient(quo16), .remainder(rem16)
   );

   seq_div #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RST(RST), .start(start8), .dividend(dvd8), .divisor(dvs8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8),
      .quotient(quo8), .remainder(rem8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic o_busy(input int w);
      return (w == 8) ? busy8 : busy16;
   endfunction
   function automatic logic o_done(input int w);
      return (w == 8) ? done8 : done16;
   endfunction
   function automatic logic o_dbz(input int w);
      return (w == 8) ? dbz8 : dbz16;
   endfunction
   function automatic logic [31:0] o_quo(input int w);
      return (w == 8) ? {24'd0, quo8} : {16'd0, quo16};
   endfunction
   function automatic logic [31:0] o_rem(input int w);
      return (w == 8) ? {24'd0, rem8} : {16'd0, rem16};
   endfunction

   // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
   task automatic run_div(input string tag, input int w, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy, input bit disturb);
      exp_t e, got;
      logic [31:0] mask;
      int nb, n;
      mask = (w == 8) ? 32'hFF : 32'hFFFF;
      if (b == 0) begin
         e.q = mask; e.r = a; e.z = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.z = 1'b0;
      end
      sb.push_back(e);
      if (w == 8) begin
         dvd8 = a[7:0]; dvs8 = b[7:0]; start8 = 1'b1;
      end else begin
         dvd16 = a[15:0]; dvs16 = b[15:0]; start16 = 1'b1;
      end
      @(negedge CLK);
      start8 = 1'b0; start16 = 1'b0;
      if (b != 0) check({tag, "_dbz_cleared"}, 64'(o_dbz(w)), 64'd0);
      nb = 0; n = 0;
      while (!o_done(w) && n < 100) begin
         if (o_busy(w)) nb++;
         if (disturb && n == 5) begin
            start16 = 1'b1; dvd16 = 16'hBEEF; dvs16 = 16'd3;
         end
         if (disturb && n == 6) begin
            start16 = 1'b0; dvd16 = 16'h1234; dvs16 = 16'd0;
         end
         @(negedge CLK);
         n++;
      end
      start16 = 1'b0;
      check({tag, "_reached_done"}, 64'(o_done(w)), 64'd1);
      check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
      check({tag, "_busy_with_done"}, 64'(o_busy(w)), 64'd0);
      got = sb.pop_front();
      check({tag, "_quotient"}, 64'(o_quo(w)), 64'(got.q));
      check({tag, "_remainder"}, 64'(o_rem(w)), 64'(got.r));
      check({tag, "_div_by_zero"}, 64'(o_dbz(w)), 64'(got.z));
      @(negedge CLK);
      check({tag, "_done_one_cycle"}, 64'(o_done(w)), 64'd0);
      check({tag, "_idle_not_busy"}, 64'(o_busy(w)), 64'd0);
      check({tag, "_quotient_held"}, 64'(o_quo(w)), 64'(got.q));
      check({tag, "_remainder_held"}, 64'(o_rem(w)), 64'(got.r));
   endtask

   initial begin
      int seen_done;
      #2;
      check("rst_busy", 64'(busy16), 64'd0);
      check("rst_done", 64'(done16), 64'd0);
      check("rst_dbz", 64'(dbz16), 64'd0);
      check("rst_quotient", 64'(quo16), 64'd0);
      check("rst_remainder", 64'(rem16), 64'd0);
      check("rst_quotient8", 64'(quo8), 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      run_div("d105_11", 16, 105, 11, 16, 1'b0);
      run_div("d12_10", 16, 12, 10, 16, 1'b0);
      run_div("d31_5", 16, 31, 5, 16, 1'b0);
      run_div("d10_81", 16, 10, 81, 16, 1'b0);
      run_div("d15_20", 16, 15, 20, 16, 1'b0);
      run_div("d7_0", 16, 7, 0, 0, 1'b0);
      run_div("d13_4_after_dbz", 16, 13, 4, 16, 1'b0);
      run_div("d65535_1", 16, 65535, 1, 16, 1'b0);
      run_div("d65535_65535", 16, 65535, 65535, 16, 1'b0);
      run_div("d1000_7_disturbed", 16, 1000, 7, 16, 1'b1);
      run_div("w8_d200_7", 8, 200, 7, 8, 1'b0);
      run_div("w8_d255_1", 8, 255, 1, 8, 1'b0);

      // Abort mid-division: start 105/11, reset after eight iterations.
      dvd16 = 16'd105; dvs16 = 16'd11; start16 = 1'b1;
      @(negedge CLK);
      start16 = 1'b0;
      repeat (8) @(negedge CLK);
      check("abort_busy_before", 64'(busy16), 64'd1);
      RST = 1'b1;
      #1;
      check("abort_busy", 64'(busy16), 64'd0);
      check("abort_done", 64'(done16), 64'd0);
      check("abort_dbz", 64'(dbz16), 64'd0);
      check("abort_quotient", 64'(quo16), 64'd0);
      check("abort_remainder", 64'(rem16), 64'd0);
      start16 = 1'b1;
      seen_done = 0;
      repeat (2) begin
         @(negedge CLK);
         if (done16) seen_done++;
         check("start_during_rst_busy", 64'(busy16), 64'd0);
      end
      RST = 1'b0; start16 = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         if (done16) seen_done++;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      check("abort_stays_idle", 64'(busy16), 64'd0);
      run_div("d31_5_after_abort", 16, 31, 5, 16, 1'b0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width; legal values are 4..32.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a division, sampled on the rising edge of CLK.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned dividend, captured when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned divisor, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while a division is in progress (state CALC).
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking quotient and remainder valid.
REQ-009 SHALL have port div_by_zero, output, 1 bit: high when the captured divisor was zero; valid whenever done is high.
REQ-010 SHALL have port quotient, output, WIDTH bits: registered result, floor(dividend/divisor).
REQ-011 SHALL have port remainder, output, WIDTH bits: registered result, dividend mod divisor.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, CALC and DONE.
REQ-013 IDLE SHALL accept start=1, capture dividend and divisor, and clear the iteration counter.
- Captured divisor nonzero: next state CALC.
- Captured divisor zero: next state DONE.
REQ-014 CALC SHALL perform restoring division, one quotient bit per clock, MSB first.
- Each step: partial remainder (WIDTH+1 bits) = {remainder, next dividend bit}.
- If the partial remainder is >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
REQ-015 CALC SHALL last exactly WIDTH clock edges.
- If start is sampled at edge N, iterations occur at edges N+1..N+WIDTH.
- Edge N+WIDTH enters DONE with quotient and remainder final.
REQ-016 DONE SHALL assert done for exactly one cycle, then return to IDLE on the next edge unconditionally.
REQ-017 start SHALL be ignored in CALC and DONE; a new request is accepted only in IDLE.
- Minimum spacing between accepted starts: WIDTH+2 cycles.
REQ-018 Divide by zero SHALL set, at edge N+1: quotient = all ones, remainder = captured dividend, div_by_zero = 1, done = 1.
REQ-019 div_by_zero SHALL be cleared when the next start is accepted.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from done until the next accepted start.
- They may change during CALC; consumers shall use them only while done=1 or in IDLE.
REQ-021 Input changes on dividend and divisor after capture SHALL NOT affect the running division.
REQ-022 Dividend smaller than divisor SHALL yield quotient 0 and remainder = dividend.
REQ-023 A divisor of 1 SHALL yield quotient = dividend and remainder 0, including dividend = all ones.
REQ-024 busy SHALL be high exactly in CALC; done SHALL be high exactly in DONE; the two SHALL never be high together.

Reset
REQ-025 RST=1 SHALL immediately, without a clock edge, force: state IDLE, busy 0, done 0, div_by_zero 0, quotient 0, remainder 0, counter 0.
REQ-026 RST asserted mid-CALC SHALL abort the division with no done pulse.
- After RST deasserts, the first start is accepted normally.
REQ-027 start SHALL be ignored on any edge where RST is high.

Verification
REQ-028 WIDTH=16, 105/11 -> busy high 16 cycles, then done pulse, quotient 9, remainder 6, div_by_zero 0.
REQ-029 Back-to-back requests 12/10, 31/5, 10/81, 15/20, each started in IDLE -> (1,2), (6,1), (0,10), (0,15).
REQ-030 7/0 -> done one cycle after start, quotient 0xFFFF, remainder 7, div_by_zero 1, busy never high.
REQ-031 65535/1 -> quotient 65535, remainder 0; 65535/65535 -> quotient 1, remainder 0.
REQ-032 Start 105/11, assert RST at iteration 8 -> all outputs 0 immediately, no done pulse; a following 31/5 -> (6,1).
REQ-033 Start pulsed during CALC, and operands changed mid-CALC -> both ignored; result matches the originally captured operands.
REQ-034 WIDTH=8, 200/7 -> busy 8 cycles, quotient 28, remainder 4.
